bsg_tag_serial_tx: RTL and testbench

BSG_TAG_SERIAL_TX -- requirements
Module: bsg_tag_serial_tx

---
 rtl/bsg_tag_serial_tx.sv | 162 ++++++++++++++++
 tb/tb_bsg_tag_serial_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_tag_serial_tx.sv
// Serializes tag master commands (master reset run or client packet) onto en/data lines.
// First bit one cycle after accept; ready_o only in IDLE, so callers simply hold v_i until taken.
module bsg_tag_serial_tx #(
  parameter int els_p        = 16,
  parameter int lg_width_p   = 4,
  parameter int reset_ones_p = 64,
  parameter int gap_p        = 8,
  localparam int lg_els      = $clog2(els_p),
  localparam int pw          = (1 << lg_width_p) - 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic                  cmd_reset_i,
  input  logic [lg_els-1:0]     node_id_i,
  input  logic                  data_not_reset_i,
  input  logic [lg_width_p-1:0] len_i,
  input  logic [pw-1:0]         payload_i,
  output logic                  tag_en_o,
  output logic                  tag_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RST_SEQ = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] LEN     = 3'd3;
  localparam logic [2:0] DNR     = 3'd4;
  localparam logic [2:0] NODE    = 3'd5;
  localparam logic [2:0] PAYLOAD = 3'd6;
  localparam logic [2:0] GAP     = 3'd7;

  localparam int max_a   = (reset_ones_p > gap_p) ? reset_ones_p : gap_p;
  localparam int max_b   = (max_a > pw) ? max_a : pw;
  localparam int max_cnt = (max_b > lg_els) ? max_b : lg_els;
  localparam int cw      = $clog2(max_cnt + 1);
  localparam int sw      = (pw > lg_els) ? pw : lg_els;

  logic [2:0]            state, nxt_state;
  logic [cw-1:0]         cnt, nxt_cnt;
  logic [sw-1:0]         sh, nxt_sh;
  logic                  en_r, data_r, nxt_en, nxt_data, done_r;
  logic [lg_els-1:0]     node_r;
  logic                  dnr_r;
  logic [lg_width_p-1:0] len_r;
  logic [pw-1:0]         payload_r;
  logic                  accept, last;

  assign ready_o    = reset_n_i && (state == IDLE);
  assign accept     = ready_o && v_i;
  assign last       = (cnt == '0);
  assign busy_o     = (state != IDLE);
  assign tag_en_o   = en_r;
  assign tag_data_o = data_r;
  assign done_o     = done_r;

  // state/cnt describe the bit currently on the lines; cnt = bits left after this one
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt - cw'(1);
    nxt_sh    = sh >> 1;
    nxt_en    = 1'b0;
    nxt_data  = 1'b0;
    case (state)
      IDLE: begin
        nxt_cnt = cnt;
        if (accept) begin
          if (cmd_reset_i) begin
            nxt_state = RST_SEQ;
            nxt_cnt   = cw'(reset_ones_p - 1);
          end else begin
            nxt_state = START;
            nxt_cnt   = '0;
          end
        end
      end
      RST_SEQ: if (last) begin
        nxt_state = GAP;
        nxt_cnt   = cw'(gap_p - 1);
      end
      START: begin
        nxt_state = LEN;
        nxt_cnt   = cw'(lg_width_p - 1);
        nxt_sh    = sw'(len_r);
      end
      LEN: if (last) begin
        nxt_state = DNR;
        nxt_cnt   = '0;
        nxt_sh    = sw'(dnr_r);
      end
      DNR: begin
        nxt_state = NODE;
        nxt_cnt   = cw'(lg_els - 1);
        nxt_sh    = sw'(node_r);
      end
      NODE: if (last) begin
        if (len_r == '0) begin
          nxt_state = GAP;
          nxt_cnt   = cw'(gap_p - 1);
        end else begin
          nxt_state = PAYLOAD;
          nxt_cnt   = cw'(len_r) - cw'(1);
          nxt_sh    = sw'(payload_r);
        end
      end
      PAYLOAD: if (last) begin
        nxt_state = GAP;
        nxt_cnt   = cw'(gap_p - 1);
      end
      GAP: if (last) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase

    case (nxt_state)
      RST_SEQ, START: begin
        nxt_en   = 1'b1;
        nxt_data = 1'b1;
      end
      LEN, DNR, NODE, PAYLOAD: begin
        nxt_en   = 1'b1;
        nxt_data = nxt_sh[0];
      end
      default: begin
        nxt_en   = 1'b0;
        nxt_data = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      en_r      <= 1'b0;
      data_r    <= 1'b0;
      done_r    <= 1'b0;
      node_r    <= '0;
      dnr_r     <= 1'b0;
      len_r     <= '0;
      payload_r <= '0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      sh     <= nxt_sh;
      en_r   <= nxt_en;
      data_r <= nxt_data;
      done_r <= (state == GAP) && last;
      if (accept) begin
        node_r    <= node_id_i;
        dnr_r     <= data_not_reset_i;
        len_r     <= len_i;
        payload_r <= payload_i;
      end
    end
  end

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Randomized and directed bench for bsg_tag_serial_tx against a bit-list reference model.
module tb_bsg_tag_serial_tx;
  localparam int els_p        = 16;
  localparam int lg_width_p   = 4;
  localparam int reset_ones_p = 64;
  localparam int gap_p        = 8;
  localparam int lg_els       = 4;
  localparam int pw           = 15;

  typedef struct packed {
    logic                  rst;
    logic [lg_width_p-1:0] len;
    logic                  dnr;
    logic [lg_els-1:0]     node;
    logic [pw-1:0]         pl;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n, v, ready, cmd_reset, dnr, tag_en, tag_data, busy, done;
  logic [lg_els-1:0]     node;
  logic [lg_width_p-1:0] len;
  logic [pw-1:0]         payload;

  bsg_tag_serial_tx #(
    .els_p(els_p), .lg_width_p(lg_width_p), .reset_ones_p(reset_ones_p), .gap_p(gap_p)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .ready_o(ready),
    .cmd_reset_i(cmd_reset), .node_id_i(node), .data_not_reset_i(dnr),
    .len_i(len), .payload_i(payload),
    .tag_en_o(tag_en), .tag_data_o(tag_data), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the list of bits that must appear while tag_en is high.
  logic exp_bits[$];
  task automatic model(input cmd_t c);
    exp_bits.delete();
    if (c.rst) begin
      for (int i = 0; i < reset_ones_p; i++) exp_bits.push_back(1'b1);
    end else begin
      exp_bits.push_back(1'b1);
      for (int i = 0; i < lg_width_p; i++) exp_bits.push_back(c.len[i]);
      exp_bits.push_back(c.dnr);
      for (int i = 0; i < lg_els; i++) exp_bits.push_back(c.node[i]);
      for (int i = 0; i < int'(c.len); i++) exp_bits.push_back(c.pl[i]);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.rst  = ($urandom % 8 == 0);
    c.len  = lg_width_p'($urandom);
    c.dnr  = 1'($urandom);
    c.node = lg_els'($urandom);
    c.pl   = pw'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    cmd_reset = c.rst;
    len       = c.len;
    dnr       = c.dnr;
    node      = c.node;
    payload   = c.pl;
  endtask

  logic [63:0] got_bits;
  int got_n, ready_low, first_bit_cyc, last_bit_cyc;

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_cmd(input cmd_t c, input bit keep_v, input cmd_t nxt);
    int total;
    model(c);
    total = exp_bits.size() + gap_p;
    chk("ready_before_accept", ready, 1);
    drive(c);
    v = 1'b1;
    @(negedge clk);
    first_bit_cyc = cyc;
    if (keep_v) drive(nxt);
    else begin
      v = 1'b0;
      drive(rand_cmd());
    end
    got_bits  = '0;
    got_n     = 0;
    ready_low = 0;
    for (int i = 0; i < total; i++) begin
      logic ee, ed;
      ee = (i < exp_bits.size());
      ed = ee ? exp_bits[i] : 1'b0;
      chk("tag_en", tag_en, ee);
      chk("tag_data", tag_data, ed);
      chk("done_early", done, 0);
      chk("busy", busy, 1);
      if (tag_en) begin
        if (got_n < 64) got_bits[got_n] = tag_data;
        got_n++;
        last_bit_cyc = cyc;
      end
      if (!ready) ready_low++;
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("ready_after", ready, 1);
    chk("en_idle", tag_en, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    cmd_t a, b, cur, nx;
    int prev_last;
    bit kv;

    reset_n = 1'b0;
    v = 1'b1;
    drive(rand_cmd());
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_en", tag_en, 0);
      chk("rst_data", tag_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    reset_n = 1'b1;
    v = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_busy", busy, 0);

    // node 5, dnr 1, len 3, payload 101
    a = '{rst: 1'b0, len: 4'd3, dnr: 1'b1, node: 4'd5, pl: 15'b101};
    run_cmd(a, 1'b0, a);
    chk("pkt_n", got_n, 13);
    chk("pkt_bits", got_bits, 64'b1010101100111);
    chk("pkt_ready_low", ready_low, 13 + gap_p);

    a = '{rst: 1'b1, len: 4'd0, dnr: 1'b0, node: 4'd0, pl: 15'd0};
    run_cmd(a, 1'b0, a);
    chk("mrst_n", got_n, reset_ones_p);
    chk("mrst_bits", got_bits, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mrst_ready_low", ready_low, reset_ones_p + gap_p);

    a = '{rst: 1'b0, len: 4'd0, dnr: 1'b0, node: 4'd15, pl: 15'h5A5A};
    run_cmd(a, 1'b0, a);
    chk("len0_n", got_n, 10);
    chk("len0_bits", got_bits, 64'b1111000001);

    a = '{rst: 1'b0, len: 4'd15, dnr: 1'b1, node: 4'd0, pl: 15'h7FFF};
    run_cmd(a, 1'b0, a);
    chk("lenmax_n", got_n, 25);
    chk("lenmax_payload", got_bits >> 10, 64'h7FFF);

    // v held high across two packets: next start follows gap_p zeros plus the accepting idle cycle
    a = rand_cmd(); a.rst = 1'b0;
    b = rand_cmd(); b.rst = 1'b0;
    run_cmd(a, 1'b1, b);
    prev_last = last_bit_cyc;
    chk("b2b_accept_in_done", done & ready & v, 1);
    run_cmd(b, 1'b0, b);
    chk("b2b_spacing", first_bit_cyc - prev_last, gap_p + 2);

    // reset during payload bit 2 aborts the packet
    a = '{rst: 1'b0, len: 4'd6, dnr: 1'b1, node: 4'd9, pl: 15'h3F};
    drive(a);
    v = 1'b1;
    chk("abort_ready", ready, 1);
    @(negedge clk);
    v = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_pre_en", tag_en, 1);
    reset_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_en", tag_en, 0);
      chk("abort_data", tag_data, 0);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ready_low", ready, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_after", ready, 1);
    chk("abort_no_done", done, 0);
    chk("abort_en_after", tag_en, 0);

    cur = rand_cmd();
    for (int i = 0; i < 30; i++) begin
      nx = rand_cmd();
      kv = ($urandom % 3 == 0);
      run_cmd(cur, kv, nx);
      if (!kv) begin
        int k;
        k = $urandom % 3;
        for (int j = 0; j < k; j++) begin
          @(negedge clk);
          chk("idle_en", tag_en, 0);
          chk("idle_data", tag_data, 0);
          chk("idle_done", done, 0);
          chk("idle_ready", ready, 1);
        end
      end
      cur = nx;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
